band_sched: RTL and testbench
=============================

BAND_SCHED -- requirements
Module: band_sched

Interface
REQ-001 Parameter NTAPS, default 32: taps per band filter job; legal range 2..1024.
REQ-002 Parameter MAC_LAT, default 2: cycles from the last mac_en of a job to the accumulator result being valid; legal range 1..4.
REQ-003 Parameter WARMUP, default 1024: accepted samples required before queues are declared primed.
REQ-004 clk  in  1  system clock, 50MHz.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 valid  in  1  one-cycle pulse per new stereo sample pair from the CODEC interface.
REQ-007 clr_ovr  in  1  synchronous clear of the sticky overrun flag.
REQ-008 mac_en  out  1  MAC accumulate strobe for the current tap.
REQ-009 mac_clr  out  1  accumulator clear, coincident with the first tap of each job.
REQ-010 tap_idx  out  clog2(NTAPS)  coefficient/queue read index for the current tap.
REQ-011 band  out  3  band of the current job: 0=LP, 1=B1, 2=B2, 3=B3, 4=HP.
REQ-012 chan  out  1  channel of the current job: 0=left, 1=right.
REQ-013 acc_cap  out  1  one-cycle capture strobe, accumulator result valid.
REQ-014 cap_band  out  3  band tag for acc_cap.
REQ-015 cap_chan  out  1  channel tag for acc_cap.
REQ-016 frame_done  out  1  one-cycle pulse, all 10 jobs of a frame captured.
REQ-017 busy  out  1  frame in progress.
REQ-018 sequencing  out  1  queues primed; gates amplifier enable at top level.
REQ-019 overrun  out  1  sticky flag: valid arrived while busy.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN: IDLE->RUN on accepted valid; RUN->DRAIN after the last tap of job 9; DRAIN->IDLE after the last acc_cap.
REQ-021 valid SHALL be accepted only while busy==0; an accepted valid in cycle 0 SHALL produce the first mac_en in cycle 1.
REQ-022 Job order SHALL be (LP,L),(LP,R),(B1,L),(B1,R),...,(HP,R); 10 jobs per frame, run back to back with no idle cycles.
REQ-023 Within a job, tap_idx SHALL count 0..NTAPS-1, one per cycle with mac_en high; mac_clr SHALL be high only at tap_idx==0.
REQ-024 mac_en, mac_clr SHALL be low in IDLE and DRAIN; tap_idx, band and chan SHALL hold their last values outside RUN.
REQ-025 acc_cap SHALL pulse exactly MAC_LAT cycles after the last mac_en of each job, with cap_band and cap_chan equal to that job's band and chan; tags SHALL travel through a MAC_LAT-deep delay line.
REQ-026 frame_done SHALL pulse the cycle after the tenth acc_cap; busy SHALL be high from cycle 1 through the tenth-acc_cap cycle and low in the frame_done cycle.
REQ-027 A valid pulse arriving during the frame_done cycle SHALL be accepted and start a new frame.
REQ-028 A valid pulse arriving while busy==1 SHALL be ignored and SHALL set overrun; the frame in progress SHALL be unaffected.
REQ-029 clr_ovr SHALL clear overrun; if valid while busy coincides with clr_ovr, overrun SHALL be set (set wins).
REQ-030 An accepted-sample counter SHALL saturate at WARMUP; sequencing SHALL rise the cycle after the WARMUP-th accepted valid and remain high until reset.
REQ-031 Ignored (overrun) valid pulses SHALL NOT advance the warmup counter.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE and all outputs, counters and the tag delay line to 0, including mid-frame; no acc_cap or frame_done SHALL follow the release of reset.

Structure
REQ-033 Band encodings (LP..HP), NUM_BANDS=5 and the jobs-per-frame constant SHALL reside in the shared equalizer package.
REQ-034 The tag delay line SHALL be a sub-module named cap_tag_pipe (parameter MAC_LAT; inputs: strobe, band, chan).

Verification
REQ-035 NTAPS=4, MAC_LAT=2, valid@0 -> mac_en high cycles 1..40, mac_clr at 1,5,...,37, acc_cap at 6,10,...,42, frame_done at 43.
REQ-036 Same configuration -> acc_cap tags in order (0,0),(0,1),(1,0),...,(4,1); tap_idx sequence 0,1,2,3 repeated.
REQ-037 valid@0 and valid@20 -> overrun=1 from cycle 21, frame timing unchanged; clr_ovr@50 -> overrun=0 at 51.
REQ-038 valid@0 and valid@43 -> second frame's first mac_en at cycle 44, no overrun.
REQ-039 WARMUP=8, eight valid pulses spaced 50 cycles apart plus one overrun pulse -> sequencing rises only after the eighth accepted valid.
REQ-040 rst_n asserted at cycle 15 of a frame -> all outputs 0 immediately; no acc_cap during 100 cycles after release without valid.

Source files
------------

// File: rtl/band_sched_pkg.sv
// ---------------------------------------------------------------------------
// band_sched_pkg
// Shared equalizer definitions: band encodings, band count, jobs per frame
// and the scheduler state encoding.
// ---------------------------------------------------------------------------
package band_sched_pkg;

  typedef enum logic [2:0] {
    BAND_LP = 3'd0,
    BAND_B1 = 3'd1,
    BAND_B2 = 3'd2,
    BAND_B3 = 3'd3,
    BAND_HP = 3'd4
  } band_e;

  localparam int NUM_BANDS      = 5;
  localparam int NUM_CHANS      = 2;
  localparam int JOBS_PER_FRAME = NUM_BANDS * NUM_CHANS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/band_sched_cap_tag_pipe.sv
// ---------------------------------------------------------------------------
// cap_tag_pipe
// MAC_LAT-deep delay line carrying the end-of-job strobe together with the
// band/channel tag of that job, so the capture strobe lines up with the
// accumulator result.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   strobe      last tap of a job is being issued this cycle
//   band, chan  tag of the job issuing that last tap
//   cap         strobe delayed by MAC_LAT cycles
//   cap_band    band tag delayed by MAC_LAT cycles
//   cap_chan    channel tag delayed by MAC_LAT cycles
// ---------------------------------------------------------------------------
module cap_tag_pipe #(
  parameter int MAC_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [2:0] band,
  input  logic       chan,
  output logic       cap,
  output logic [2:0] cap_band,
  output logic       cap_chan
);

  logic       vld_p  [MAC_LAT];
  logic [2:0] band_p [MAC_LAT];
  logic       chan_p [MAC_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        band_p[i] <= 3'd0;
        chan_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0]  <= strobe;
      band_p[0] <= band;
      chan_p[0] <= chan;
      for (int i = 1; i < MAC_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        band_p[i] <= band_p[i-1];
        chan_p[i] <= chan_p[i-1];
      end
    end
  end

  assign cap      = vld_p[MAC_LAT-1];
  assign cap_band = band_p[MAC_LAT-1];
  assign cap_chan = chan_p[MAC_LAT-1];

endmodule

// File: rtl/band_sched.sv
// ---------------------------------------------------------------------------
// band_sched
// Per-sample scheduler for the 5-band stereo equalizer. Each accepted sample
// starts a frame of 10 filter jobs (band-major, left then right), each job
// issuing NTAPS consecutive MAC strobes. Capture strobes follow each job's
// last tap by MAC_LAT cycles. Also tracks overrun and queue warm-up.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid        new stereo sample pair (accepted only while idle)
//   clr_ovr      clear the sticky overrun flag
//   mac_en       MAC accumulate strobe
//   mac_clr      accumulator clear on the first tap of a job
//   tap_idx      coefficient/queue read index
//   band, chan   tag of the job currently issuing taps
//   acc_cap      accumulator result valid
//   cap_band/chan tag of the captured result
//   frame_done   all jobs of the frame captured
//   busy         frame in progress
//   sequencing   queues primed (WARMUP samples accepted)
//   overrun      sticky: valid arrived while busy
// ---------------------------------------------------------------------------
module band_sched
  import band_sched_pkg::*;
#(
  parameter int NTAPS   = 32,
  parameter int MAC_LAT = 2,
  parameter int WARMUP  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic                     clr_ovr,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic [$clog2(NTAPS)-1:0] tap_idx,
  output logic [2:0]               band,
  output logic                     chan,
  output logic                     acc_cap,
  output logic [2:0]               cap_band,
  output logic                     cap_chan,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     sequencing,
  output logic                     overrun
);

  localparam int TAP_W = $clog2(NTAPS);
  localparam int CNT_W = $clog2(WARMUP + 1);

  sched_state_e     state, state_nxt;
  logic             accept;
  logic             last_tap;
  logic             last_job;
  logic             job_end;
  logic             frame_end;
  logic [CNT_W-1:0] warm_cnt;

  assign accept    = valid && (state == S_IDLE);
  assign last_tap  = (tap_idx == TAP_W'(NTAPS - 1));
  assign last_job  = (band == 3'(BAND_HP)) && chan;
  assign job_end   = mac_en && last_tap;
  // Only the final job of a frame carries the (HP, right) tag, so its
  // capture marks the end of the frame.
  assign frame_end = acc_cap && (cap_band == 3'(BAND_HP)) && cap_chan;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt = state;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        mac_en  = 1'b1;
        mac_clr = (tap_idx == '0);
        busy    = 1'b1;
        if (last_tap && last_job) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (frame_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tap / job sequencing; values hold once the last tap of the frame issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx <= '0;
      band    <= 3'd0;
      chan    <= 1'b0;
    end else if (accept) begin
      tap_idx <= '0;
      band    <= 3'(BAND_LP);
      chan    <= 1'b0;
    end else if (state == S_RUN) begin
      if (!last_tap) begin
        tap_idx <= tap_idx + TAP_W'(1);
      end else if (!last_job) begin
        tap_idx <= '0;
        if (chan) begin
          chan <= 1'b0;
          band <= band + 3'd1;
        end else begin
          chan <= 1'b1;
        end
      end
    end
  end

  // Frame completion, overrun and warm-up tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      warm_cnt   <= '0;
    end else begin
      frame_done <= frame_end;
      if (valid && busy)  overrun <= 1'b1;
      else if (clr_ovr)   overrun <= 1'b0;
      if (accept && (warm_cnt != CNT_W'(WARMUP)))
        warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  assign sequencing = (warm_cnt == CNT_W'(WARMUP));

  cap_tag_pipe #(
    .MAC_LAT(MAC_LAT)
  ) u_cap_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (job_end),
    .band    (band),
    .chan    (chan),
    .cap     (acc_cap),
    .cap_band(cap_band),
    .cap_chan(cap_chan)
  );

endmodule

// File: tb/tb_band_sched.sv
// ---------------------------------------------------------------------------
// tb_band_sched
// Drives band_sched with a directed opening sequence, then random valid /
// clr_ovr traffic, then a mid-frame reset. Every cycle the outputs are
// compared against a frame-timing model derived from the accept cycle.
// ---------------------------------------------------------------------------
module tb_band_sched;

  localparam int NTAPS     = 4;
  localparam int MAC_LAT   = 2;
  localparam int WARMUP    = 8;
  localparam int NJOBS     = 10;
  localparam int FRAME_LEN = NTAPS * NJOBS;
  localparam int TAP_W     = $clog2(NTAPS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid;
  logic             clr_ovr;
  logic             mac_en;
  logic             mac_clr;
  logic [TAP_W-1:0] tap_idx;
  logic [2:0]       band;
  logic             chan;
  logic             acc_cap;
  logic [2:0]       cap_band;
  logic             cap_chan;
  logic             frame_done;
  logic             busy;
  logic             sequencing;
  logic             overrun;

  band_sched #(
    .NTAPS  (NTAPS),
    .MAC_LAT(MAC_LAT),
    .WARMUP (WARMUP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .clr_ovr   (clr_ovr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .tap_idx   (tap_idx),
    .band      (band),
    .chan      (chan),
    .acc_cap   (acc_cap),
    .cap_band  (cap_band),
    .cap_chan  (cap_chan),
    .frame_done(frame_done),
    .busy      (busy),
    .sequencing(sequencing),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = -1;

  // Reference model state: the accept cycle of the latest frame fully
  // determines every strobe of that frame.
  bit have_fs;
  int fs;
  bit m_ovr;
  int m_warm;
  int m_tap, m_band, m_chan;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit m_busy();
    return have_fs && (cyc >= fs + 1) && (cyc <= fs + FRAME_LEN + MAC_LAT);
  endfunction

  task automatic model_reset();
    have_fs = 1'b0;
    fs      = 0;
    m_ovr   = 1'b0;
    m_warm  = 0;
    m_tap   = 0;
    m_band  = 0;
    m_chan  = 0;
  endtask

  task automatic check_cycle();
    int k, d, cj;
    bit run, cap, done;
    k   = cyc - fs - 1;
    run = have_fs && (k >= 0) && (k < FRAME_LEN);
    if (run) begin
      m_tap  = k % NTAPS;
      m_band = (k / NTAPS) / 2;
      m_chan = (k / NTAPS) % 2;
    end
    // Job j's last tap is at fs + NTAPS*(j+1); capture follows by MAC_LAT.
    d   = cyc - fs - MAC_LAT;
    cap = have_fs && (d > 0) && (d % NTAPS == 0) && (d / NTAPS <= NJOBS);
    cj  = d / NTAPS - 1;
    done = have_fs && (cyc == fs + FRAME_LEN + MAC_LAT + 1);
    chk("mac_en",  int'(mac_en),  int'(run));
    chk("mac_clr", int'(mac_clr), int'(run && (k % NTAPS == 0)));
    chk("tap_idx", int'(tap_idx), m_tap);
    chk("band",    int'(band),    m_band);
    chk("chan",    int'(chan),    m_chan);
    chk("acc_cap", int'(acc_cap), int'(cap));
    if (cap) begin
      chk("cap_band", int'(cap_band), cj / 2);
      chk("cap_chan", int'(cap_chan), cj % 2);
    end
    chk("frame_done", int'(frame_done), int'(done));
    chk("busy",       int'(busy),       int'(m_busy()));
    chk("overrun",    int'(overrun),    int'(m_ovr));
    chk("sequencing", int'(sequencing), int'(m_warm == WARMUP));
  endtask

  task automatic drive(input bit v, input bit c);
    valid   = v;
    clr_ovr = c;
    if (v) begin
      if (m_busy()) begin
        m_ovr = 1'b1;
      end else begin
        have_fs = 1'b1;
        fs      = cyc;
        if (m_warm < WARMUP) m_warm++;
      end
    end else if (c) begin
      m_ovr = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mac_en"},     int'(mac_en),     0);
    chk({tag, "_mac_clr"},    int'(mac_clr),    0);
    chk({tag, "_tap_idx"},    int'(tap_idx),    0);
    chk({tag, "_band"},       int'(band),       0);
    chk({tag, "_chan"},       int'(chan),       0);
    chk({tag, "_acc_cap"},    int'(acc_cap),    0);
    chk({tag, "_cap_band"},   int'(cap_band),   0);
    chk({tag, "_cap_chan"},   int'(cap_chan),   0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_busy"},       int'(busy),       0);
    chk({tag, "_sequencing"}, int'(sequencing), 0);
    chk({tag, "_overrun"},    int'(overrun),    0);
  endtask

  initial begin
    bit v, c;
    rst_n   = 1'b0;
    valid   = 1'b0;
    clr_ovr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < 1720; i++) begin
      @(negedge clk);
      cyc = i;
      check_cycle();
      v = 1'b0;
      c = 1'b0;
      if (i < 100) begin
        // Overrun during a frame, clear later, back-to-back frame start.
        v = (i == 0) || (i == 20) || (i == 43);
        c = (i == 50);
      end else if (i < 1500) begin
        v = ($urandom_range(0, 29) == 0);
        c = ($urandom_range(0, 19) == 0);
      end else begin
        v = (i == 1600);
      end
      drive(v, c);
      if (i == 1615) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
      end
      if (i == 1619) rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
